switch_ddf_ms: RTL and testbench



---
 rtl/ddf_pkg.sv | 22 ++
 rtl/switch_ddf_rr_arb.sv | 53 +++++
 rtl/switch_ddf_ms.sv | 155 +++++++++++++++
 tb/tb_switch_ddf_ms.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddf_pkg.sv
// Shared definitions for the dynamic-dataflow actors: per-flow state
// encoding, a constant clog2, and the flat (flow, port) lane index helper.
package ddf_pkg;

    typedef enum logic {
        S_WAIT_SEL = 1'b0,
        S_ROUTE    = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bit position of (flow f, port p) in the out_full / out_wr vectors.
    function automatic int lane_idx(input int f, input int p, input int ports);
        return f * ports + p;
    endfunction

endpackage

// File: rtl/switch_ddf_rr_arb.sv
// Round-robin grant for one output port across N requesting flows.
// The pointer only moves when two or more flows competed in a cycle;
// it then lands one past the winner so the winner goes last next time.
module switch_ddf_rr_arb
    import ddf_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // First requester at or above the pointer (wrapping) wins; count competitors
    always_comb begin
        int  idx;
        int  cnt;
        int  win;
        logic found;
        gnt   = '0;
        idx   = 0;
        cnt   = 0;
        win   = int'(ptr_q);
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx -= N;
            if (req[idx]) begin
                cnt++;
                if (!found) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    win      = idx;
                end
            end
        end
        ptr_d = ptr_q;
        if (cnt > 1) ptr_d = (win + 1 >= N) ? '0 : PW'(win + 1);
    end

    // Pointer register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/switch_ddf_ms.sv
// Multi-stream dynamic-dataflow SWITCH: each flow pops a control token,
// then routes its next data token to the output port the token selects.
// Optional SWITCH_DDF_RANGE_CHECK_EN: out-of-range selectors raise a sticky
// err and their data token is dropped instead of stalling the flow.
module switch_ddf_ms
    import ddf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    parameter int PORTS = 2
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic [FLUX-1:0]         sel_empty,
    output logic [FLUX-1:0]         sel_read,
    input  logic [FLUX*WIDTH-1:0]   sel_data,
    input  logic [FLUX-1:0]         in_empty,
    output logic [FLUX-1:0]         in_read,
    input  logic [FLUX*WIDTH-1:0]   in_data,
    input  logic [PORTS*FLUX-1:0]   out_full,
    output logic [PORTS*FLUX-1:0]   out_wr,
    output logic [PORTS*WIDTH-1:0]  out_data
`ifdef SWITCH_DDF_RANGE_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int SELW = clog2(PORTS);

    state_t                    state_q [FLUX];
    state_t                    state_d [FLUX];
    logic [WIDTH-1:0]          sel_q   [FLUX];
    logic [WIDTH-1:0]          sel_d   [FLUX];
    logic [SELW-1:0]           tgt     [FLUX];
    logic [FLUX-1:0]           tgt_ok;
    logic [FLUX-1:0]           drop;
    logic [FLUX-1:0]           fire;
    logic [FLUX-1:0]           done;
    logic [PORTS-1:0][FLUX-1:0] req;
    logic [PORTS-1:0][FLUX-1:0] gnt;

    // Decode each latched selector into a target port and its validity
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            tgt[f] = sel_q[f][SELW-1:0];
`ifdef SWITCH_DDF_RANGE_CHECK_EN
            tgt_ok[f] = int'(sel_q[f]) < PORTS;
            drop[f]   = (state_q[f] == S_ROUTE) && !tgt_ok[f] && !in_empty[f];
`else
            // Truncated selector beyond the last port never requests: flow stalls.
            tgt_ok[f] = int'(tgt[f]) < PORTS;
            drop[f]   = 1'b0;
`endif
        end
    end

    // A flow requests its target port when it has data and the port has room
    always_comb begin
        req = '0;
        for (int f = 0; f < FLUX; f++)
            for (int p = 0; p < PORTS; p++)
                if (int'(tgt[f]) == p)
                    req[p][f] = (state_q[f] == S_ROUTE) && tgt_ok[f] && !in_empty[f]
                                && !out_full[lane_idx(f, p, PORTS)];
    end

    genvar gp;
    generate
        for (gp = 0; gp < PORTS; gp++) begin : g_arb
            switch_ddf_rr_arb #(.N(FLUX)) u_arb (
                .ck  (ck),
                .rst (rst),
                .req (req[gp]),
                .gnt (gnt[gp])
            );
        end
    endgenerate

    // Output strobes and data muxing from the grants; sel_read reloads on a fire
    always_comb begin
        fire     = '0;
        done     = '0;
        out_wr   = '0;
        out_data = '0;
        in_read  = '0;
        sel_read = '0;
        for (int p = 0; p < PORTS; p++)
            for (int f = 0; f < FLUX; f++)
                if (gnt[p][f]) begin
                    fire[f]                          = 1'b1;
                    out_wr[lane_idx(f, p, PORTS)]    = 1'b1;
                    out_data[p*WIDTH +: WIDTH]       = in_data[f*WIDTH +: WIDTH];
                end
        for (int f = 0; f < FLUX; f++) begin
            done[f]     = fire[f] | drop[f];
            in_read[f]  = done[f];
            sel_read[f] = !rst && !sel_empty[f] && ((state_q[f] == S_WAIT_SEL) || done[f]);
        end
    end

    // Next state: a control pop always leads to ROUTE; a fire without one returns to WAIT
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            state_d[f] = state_q[f];
            sel_d[f]   = sel_q[f];
            if (sel_read[f]) begin
                state_d[f] = S_ROUTE;
                sel_d[f]   = sel_data[f*WIDTH +: WIDTH];
            end else if (done[f]) begin
                state_d[f] = S_WAIT_SEL;
            end
        end
    end

    // Per-flow state and selector registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= S_WAIT_SEL;
                sel_q[f]   <= '0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= state_d[f];
                sel_q[f]   <= sel_d[f];
            end
        end
    end

`ifdef SWITCH_DDF_RANGE_CHECK_EN
    logic [FLUX-1:0] bad;

    // Any routing flow holding an out-of-range selector is an error
    always_comb begin
        for (int f = 0; f < FLUX; f++)
            bad[f] = (state_q[f] == S_ROUTE) && !tgt_ok[f];
    end

    // Sticky error flag
    always_ff @(posedge ck or posedge rst) begin
        if (rst)       err <= 1'b0;
        else if (|bad) err <= 1'b1;
    end
`else
    logic unused_sel;

    // Upper selector bits are deliberately ignored in the truncating build
    always_comb begin
        unused_sel = 1'b0;
        for (int f = 0; f < FLUX; f++) unused_sel = unused_sel ^ (^sel_q[f]);
    end
`endif

endmodule

// File: tb/tb_switch_ddf_ms.sv
// Self-checking bench for switch_ddf_ms: directed scenarios plus a randomized
// run against a per-flow (port, data) scoreboard fed by FIFO models.
module tb_switch_ddf_ms;

    localparam int W    = 8;
    localparam int FLUX = 2;
`ifdef SWITCH_DDF_RANGE_CHECK_EN
    localparam int PORTS = 3;
`else
    localparam int PORTS = 2;
`endif

    logic                   ck = 1'b0;
    logic                   rst;
    logic [FLUX-1:0]        sel_empty, sel_read, in_empty, in_read;
    logic [FLUX*W-1:0]      sel_data, in_data;
    logic [PORTS*FLUX-1:0]  out_full, out_wr;
    logic [PORTS*W-1:0]     out_data;
`ifdef SWITCH_DDF_RANGE_CHECK_EN
    logic                   err;
`endif

    int checks;
    int errors;

    // Upstream FIFO contents and the expected (port, data) stream per flow
    logic [W-1:0] selq [FLUX][$];
    logic [W-1:0] datq [FLUX][$];
    int           refp [FLUX][$];
    logic [W-1:0] refd [FLUX][$];

    logic [PORTS*FLUX-1:0] ew;

    always #5 ck = ~ck;

    switch_ddf_ms #(.WIDTH(W), .FLUX(FLUX), .PORTS(PORTS)) dut (
        .ck        (ck),
        .rst       (rst),
        .sel_empty (sel_empty),
        .sel_read  (sel_read),
        .sel_data  (sel_data),
        .in_empty  (in_empty),
        .in_read   (in_read),
        .in_data   (in_data),
        .out_full  (out_full),
        .out_wr    (out_wr),
        .out_data  (out_data)
`ifdef SWITCH_DDF_RANGE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    function automatic int lane(input int f, input int p);
        return f * PORTS + p;
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        sel_empty = '1;
        in_empty  = '1;
        sel_data  = '0;
        in_data   = '0;
        out_full  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        for (int f = 0; f < FLUX; f++) begin
            selq[f].delete();
            datq[f].delete();
            refp[f].delete();
            refd[f].delete();
        end
    endtask

    task automatic push_tok(input int f, input int p, input logic [W-1:0] d);
        selq[f].push_back(W'(p));
        datq[f].push_back(d);
        refp[f].push_back(p);
        refd[f].push_back(d);
    endtask

    function automatic bit pending();
        for (int f = 0; f < FLUX; f++)
            if (refp[f].size() != 0 || selq[f].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Drive FIFO models cycle by cycle and score every write against refp/refd
    task automatic run_queues(input int budget, input int full_pct, input int bub_pct,
                              output int used);
        int nw;
        logic [W-1:0] got;
        logic wrote;
        used = 0;
        while (pending() && used < budget) begin
            for (int f = 0; f < FLUX; f++) begin
                sel_empty[f] = (selq[f].size() == 0) || ($urandom_range(99) < bub_pct);
                sel_data[f*W +: W] = (selq[f].size() != 0) ? selq[f][0] : '0;
                in_empty[f] = (datq[f].size() == 0) || ($urandom_range(99) < bub_pct);
                in_data[f*W +: W] = (datq[f].size() != 0) ? datq[f][0] : '0;
            end
            for (int i = 0; i < PORTS*FLUX; i++) out_full[i] = ($urandom_range(99) < full_pct);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                nw  = 0;
                got = out_data[p*W +: W];
                for (int f = 0; f < FLUX; f++) begin
                    if (out_wr[lane(f, p)]) begin
                        nw++;
                        checks++;
                        if (refp[f].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write flow %0d port %0d got %0h want none", f, p, got);
                        end else if (refp[f][0] != p || refd[f][0] !== got ||
                                     out_full[lane(f, p)] || !in_read[f]) begin
                            errors++;
                            $display("FAIL route flow %0d got port %0d data %0h full %0b rd %0b want port %0d data %0h",
                                     f, p, got, out_full[lane(f, p)], in_read[f], refp[f][0], refd[f][0]);
                        end
                    end
                end
                checks++;
                if (nw > 1) begin
                    errors++;
                    $display("FAIL port_collision port %0d got %0d writers want <=1", p, nw);
                end
                if (nw == 0) begin
                    checks++;
                    if (got !== '0) begin
                        errors++;
                        $display("FAIL idle_data port %0d got %0h want 0", p, got);
                    end
                end
            end
            for (int f = 0; f < FLUX; f++) begin
                wrote = 1'b0;
                for (int p = 0; p < PORTS; p++) wrote = wrote | out_wr[lane(f, p)];
                checks++;
                if (in_read[f] !== wrote || (in_read[f] && in_empty[f]) || (sel_read[f] && sel_empty[f])) begin
                    errors++;
                    $display("FAIL pop_strobes flow %0d got rd %0b srd %0b want rd %0b (empty %0b/%0b)",
                             f, in_read[f], sel_read[f], wrote, in_empty[f], sel_empty[f]);
                end
                if (sel_read[f] && selq[f].size() != 0) void'(selq[f].pop_front());
                if (in_read[f] && datq[f].size() != 0) void'(datq[f].pop_front());
                if (in_read[f] && refp[f].size() != 0) begin
                    void'(refp[f].pop_front());
                    void'(refd[f].pop_front());
                end
            end
            used++;
            step();
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL timeout got %0d cycles want all tokens delivered", used);
        end
        idle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sel_empty = '0;
        in_empty  = '0;
        sel_data  = W*FLUX'($urandom);
        in_data   = W*FLUX'($urandom);
        #1;
        checks++;
        if (sel_read !== '0 || in_read !== '0) begin
            errors++;
            $display("FAIL reset_reads got %0h/%0h want 0/0", sel_read, in_read);
        end
        checks++;
        if (out_wr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h/%0h want 0/0", out_wr, out_data);
        end
`ifdef SWITCH_DDF_RANGE_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %0b want 0", err);
        end
`endif
        step();
        idle();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        idle();
        sel_empty[0] = 1'b0;
        sel_data[0 +: W] = 8'd1;
        in_empty[0] = 1'b0;
        in_data[0 +: W] = 8'hA5;
        #1;
        checks++;
        if (sel_read !== 2'b01 || out_wr !== '0) begin
            errors++;
            $display("FAIL basic_c0 got srd %0b wr %0h want 01 / 0", sel_read, out_wr);
        end
        step();
        sel_empty[0] = 1'b1;
        #1;
        ew = '0;
        ew[lane(0, 1)] = 1'b1;
        checks++;
        if (out_wr !== ew || in_read !== 2'b01) begin
            errors++;
            $display("FAIL basic_c1_strobes got wr %0h rd %0b want %0h / 01", out_wr, in_read, ew);
        end
        checks++;
        if (out_data[W +: W] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_c1_data got %0h want a5", out_data[W +: W]);
        end
        step();
        idle();
        #1;
        checks++;
        if (out_wr !== '0 || in_read !== '0 || sel_read !== '0) begin
            errors++;
            $display("FAIL basic_idle got %0h/%0b/%0b want 0", out_wr, in_read, sel_read);
        end
        step();
    endtask

    task automatic test_backpressure();
        idle();
        sel_empty[0] = 1'b0;
        sel_data[0 +: W] = 8'd1;
        in_empty[0] = 1'b0;
        in_data[0 +: W] = 8'h3C;
        out_full[lane(0, 1)] = 1'b1;
        #1;
        checks++;
        if (sel_read !== 2'b01) begin
            errors++;
            $display("FAIL bp_sel_read got %0b want 01", sel_read);
        end
        step();
        sel_empty[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_read !== '0 || out_wr !== '0 || sel_read !== '0) begin
                errors++;
                $display("FAIL bp_stall cycle %0d got rd %0b wr %0h srd %0b want 0", c, in_read, out_wr, sel_read);
            end
            step();
        end
        out_full = '0;
        #1;
        ew = '0;
        ew[lane(0, 1)] = 1'b1;
        checks++;
        if (out_wr !== ew || in_read !== 2'b01 || out_data[W +: W] !== 8'h3C) begin
            errors++;
            $display("FAIL bp_release got wr %0h rd %0b data %0h want %0h / 01 / 3c",
                     out_wr, in_read, out_data[W +: W], ew);
        end
        step();
        idle();
    endtask

    task automatic test_conflict();
        logic [FLUX-1:0] er;
        logic [W-1:0]    ed;
        int              f;
        do_reset();
        // Fresh pointer favours flow0; the conflict moves it past flow0 for the rerun.
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            sel_empty = '0;
            in_empty  = '0;
            in_data   = {8'h22, 8'h11};
            #1;
            checks++;
            if (sel_read !== 2'b11) begin
                errors++;
                $display("FAIL conflict_sel pass %0d got %0b want 11", pass, sel_read);
            end
            step();
            sel_empty = '1;
            for (int k = 0; k < 2; k++) begin
                f = (pass + k) % 2;
                #1;
                ew = '0;
                ew[lane(f, 0)] = 1'b1;
                er = '0;
                er[f] = 1'b1;
                ed = (f == 0) ? 8'h11 : 8'h22;
                checks++;
                if (out_wr !== ew || in_read !== er || out_data[0 +: W] !== ed) begin
                    errors++;
                    $display("FAIL conflict pass %0d slot %0d got wr %0h rd %0b data %0h want %0h / %0b / %0h",
                             pass, k, out_wr, in_read, out_data[0 +: W], ew, er, ed);
                end
                step();
                in_empty[f] = 1'b1;
            end
            idle();
        end
    endtask

    task automatic test_parallel();
        int used;
        do_reset();
        clear_q();
        for (int k = 0; k < 8; k++) begin
            push_tok(0, 0, W'($urandom));
            push_tok(1, 1, W'($urandom));
        end
        run_queues(50, 0, 0, used);
        checks++;
        if (used !== 9) begin
            errors++;
            $display("FAIL parallel_cycles got %0d want 9", used);
        end
    endtask

    task automatic test_random();
        int used;
        do_reset();
        clear_q();
        for (int f = 0; f < FLUX; f++)
            for (int k = 0; k < 24; k++)
                push_tok(f, $urandom_range(PORTS-1), W'($urandom));
        run_queues(3000, 30, 20, used);
    endtask

`ifdef SWITCH_DDF_RANGE_CHECK_EN
    task automatic test_range();
        do_reset();
        idle();
        sel_empty[0] = 1'b0;
        sel_data[0 +: W] = 8'd3;
        in_empty[0] = 1'b0;
        in_data[0 +: W] = 8'h77;
        #1;
        checks++;
        if (sel_read !== 2'b01) begin
            errors++;
            $display("FAIL range_sel got %0b want 01", sel_read);
        end
        step();
        sel_data[0 +: W] = 8'd2;
        #1;
        checks++;
        if (in_read !== 2'b01 || out_wr !== '0 || sel_read !== 2'b01) begin
            errors++;
            $display("FAIL range_drop got rd %0b wr %0h srd %0b want 01 / 0 / 01", in_read, out_wr, sel_read);
        end
        step();
        sel_empty[0] = 1'b1;
        in_data[0 +: W] = 8'h88;
        #1;
        ew = '0;
        ew[lane(0, 2)] = 1'b1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL range_err got %0b want 1", err);
        end
        checks++;
        if (out_wr !== ew || out_data[2*W +: W] !== 8'h88) begin
            errors++;
            $display("FAIL range_next got wr %0h data %0h want %0h / 88", out_wr, out_data[2*W +: W], ew);
        end
        step();
        idle();
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL range_sticky got %0b want 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL range_clear got %0b want 0", err);
        end
    endtask
`endif

    task automatic test_reset_midop();
        do_reset();
        idle();
        sel_empty[0] = 1'b0;
        sel_data[0 +: W] = 8'd1;
        #1;
        step();
        sel_empty[0] = 1'b1;
        in_empty[0] = 1'b0;
        in_data[0 +: W] = 8'h5A;
        #1;
        ew = '0;
        ew[lane(0, 1)] = 1'b1;
        checks++;
        if (out_wr !== ew) begin
            errors++;
            $display("FAIL midop_prefire got %0h want %0h", out_wr, ew);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_wr !== '0 || in_read !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL midop_async got wr %0h rd %0b data %0h want 0", out_wr, in_read, out_data);
        end
        step();
        sel_empty[0] = 1'b0;
        sel_data[0 +: W] = 8'd0;
        rst = 1'b0;
        #1;
        checks++;
        if (sel_read !== 2'b01 || out_wr !== '0) begin
            errors++;
            $display("FAIL midop_relatch got srd %0b wr %0h want 01 / 0", sel_read, out_wr);
        end
        step();
        sel_empty[0] = 1'b1;
        #1;
        ew = '0;
        ew[lane(0, 0)] = 1'b1;
        checks++;
        if (out_wr !== ew || out_data[0 +: W] !== 8'h5A) begin
            errors++;
            $display("FAIL midop_route got wr %0h data %0h want %0h / 5a", out_wr, out_data[0 +: W], ew);
        end
        step();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        step();
        test_reset();
        test_basic();
        test_backpressure();
        test_conflict();
        test_parallel();
`ifdef SWITCH_DDF_RANGE_CHECK_EN
        test_range();
`endif
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1);
    end

endmodule
